mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's data/instruction port: accepts one word-addressed read or write request at a time over a valid/ready handshake, serves it from an internal word RAM after a fixed number of wait states, and returns read data or an error flag over a second valid/ready handshake. It is the target end of the CPU's memory interface. It replaces the zero-handshake memory so that controller states can stall on `rsp_valid` and raise misaligned and out-of-range exceptions.

---
 rtl/mem_rsp_pkg.sv | 8 +
 rtl/mem_word_ram.sv | 21 ++
 rtl/mem_responder.sv | 88 ++++++++
 tb/tb_mem_responder.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/mem_rsp_pkg.sv
// mem_rsp_pkg: shared types, constants and address checking for the memory responder.
package mem_rsp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_ST, RESP} state_t;
  localparam int WORD_BYTES = 4;
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction
endpackage

// File: rtl/mem_word_ram.sv
// mem_word_ram: word RAM with per-byte write enables and a registered read port.
module mem_word_ram
  import mem_rsp_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic [WORD_BYTES-1:0]   we,
  input  logic                    re,
  input  logic [AW-1:0]           addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata
);
  logic [31:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int i = 0; i < WORD_BYTES; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: valid/ready memory target serving word reads/writes after WAIT wait states.
module mem_responder
  import mem_rsp_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_wr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [31:0] addr_q, wdata_q, a_addr, a_wdata, ram_rdata;
  logic [3:0] be_q, a_be;
  logic wr_q, a_wr, accept, access, err, err_q, rd_ok;
  // With WAIT=0 the access happens on the accept edge, so it must use the live request.
  always_comb begin
    accept    = state == IDLE && req_valid;
    a_addr    = state == IDLE ? req_addr : addr_q;
    a_wdata   = state == IDLE ? req_wdata : wdata_q;
    a_be      = state == IDLE ? req_be : be_q;
    a_wr      = state == IDLE ? req_wr : wr_q;
    err       = addr_err(a_addr, DEPTH);
    access    = (accept && WAIT == 0) || (state == WAIT_ST && cnt == 4'd0);
    req_ready = state == IDLE;
    rsp_valid = state == RESP;
    rsp_err   = err_q;
    rsp_rdata = rd_ok ? ram_rdata : 32'd0;
    state_nx  = state;
    cnt_nx    = cnt;
    if (accept) begin
      state_nx = WAIT == 0 ? RESP : WAIT_ST;
      cnt_nx   = WAIT == 0 ? 4'd0 : 4'(WAIT - 1);
    end else if (state == WAIT_ST) begin
      state_nx = cnt == 4'd0 ? RESP : WAIT_ST;
      cnt_nx   = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
    end else if (state == RESP && rsp_ready) begin
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rd_ok   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
        wr_q    <= req_wr;
      end
      if (access) begin
        err_q <= err;
        rd_ok <= !err && !a_wr;
      end else if (state == RESP && rsp_ready) begin
        err_q <= 1'b0;
        rd_ok <= 1'b0;
      end
    end
  end
  mem_word_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (access && a_wr && !err ? a_be : 4'b0000),
    .re    (access && !a_wr && !err),
    .addr  (a_addr[AW+1:2]),
    .wdata (a_wdata),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for WAIT=2 and WAIT=0 responder instances.
module tb_mem_responder;
  logic clk = 0, reset = 1;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic req_wr = 0;
  logic [3:0] req_be = 0;
  logic vld_a = 0, vld_b = 0, rr_a = 1, rr_b = 1;
  logic rdy_a, rdy_b, rsp_valid_a, rsp_valid_b, err_a, err_b;
  logic [31:0] rdata_a, rdata_b;
  logic [32:0] qa[$], qb[$];
  logic [32:0] e;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  mem_responder #(.DEPTH(256), .WAIT(2)) dut_a (
    .clk(clk), .reset(reset), .req_valid(vld_a), .req_ready(rdy_a), .req_addr(req_addr),
    .req_wr(req_wr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid_a),
    .rsp_ready(rr_a), .rsp_rdata(rdata_a), .rsp_err(err_a)
  );
  mem_responder #(.DEPTH(256), .WAIT(0)) dut_b (
    .clk(clk), .reset(reset), .req_valid(vld_b), .req_ready(rdy_b), .req_addr(req_addr),
    .req_wr(req_wr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid_b),
    .rsp_ready(rr_b), .rsp_rdata(rdata_b), .rsp_err(err_b)
  );
  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endfunction
  always @(negedge clk) begin
    if (rsp_valid_a && rr_a) begin
      if (qa.size() == 0) begin
        total++;
        $display("FAIL unexpected_rsp_a: got rdata %h err %b expected no response", rdata_a, err_a);
      end else begin
        e = qa.pop_front();
        chk("rsp_a_rdata", rdata_a, e[31:0]);
        chk("rsp_a_err", {31'd0, err_a}, {31'd0, e[32]});
      end
    end
    if (rsp_valid_b && rr_b) begin
      if (qb.size() == 0) begin
        total++;
        $display("FAIL unexpected_rsp_b: got rdata %h err %b expected no response", rdata_b, err_b);
      end else begin
        e = qb.pop_front();
        chk("rsp_b_rdata", rdata_b, e[31:0]);
        chk("rsp_b_err", {31'd0, err_b}, {31'd0, e[32]});
      end
    end
  end
  task automatic set_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd, input logic [3:0] be);
    req_addr = addr; req_wr = wr; req_wdata = wd; req_be = be;
  endtask
  task automatic wait_accept(input bit b);
    bit ok = 0;
    repeat (50) if (!ok) begin
      @(negedge clk);
      ok = b ? rdy_b : rdy_a;
    end
    chk("accept", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    vld_a = 0; vld_b = 0;
  endtask
  task automatic issue(input bit b, input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                       input logic [3:0] be, input logic [32:0] exp, input int lat);
    bit ok = 0;
    int n = 0;
    if (b) qb.push_back(exp); else qa.push_back(exp);
    set_req(addr, wr, wd, be);
    if (b) vld_b = 1; else vld_a = 1;
    wait_accept(b);
    repeat (20) if (!ok) begin
      @(negedge clk);
      ok = b ? rsp_valid_b : rsp_valid_a;
      if (!ok) begin @(posedge clk); n++; end
    end
    chk("latency", n, lat);
    @(posedge clk); #1;
  endtask
  initial begin
    bit ok = 0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, rdy_a}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_err", {31'd0, err_a}, 32'd0);
    chk("rst_b_req_ready", {31'd0, rdy_b}, 32'd1);
    @(posedge clk); #1;
    issue(0, 32'h10, 1, 32'hDEADBEEF, 4'hF, {1'b0, 32'h0}, 2);
    issue(0, 32'h10, 0, 32'h0, 4'h0, {1'b0, 32'hDEADBEEF}, 2);
    issue(0, 32'h10, 1, 32'h000000AA, 4'h1, {1'b0, 32'h0}, 2);
    issue(0, 32'h10, 0, 32'h0, 4'h0, {1'b0, 32'hDEADBEAA}, 2);
    issue(0, 32'h0, 1, 32'h11111111, 4'hF, {1'b0, 32'h0}, 2);
    issue(0, 32'h20, 1, 32'h0BADF00D, 4'hF, {1'b0, 32'h0}, 2);
    issue(0, 32'h12, 0, 32'h0, 4'hF, {1'b1, 32'h0}, 2);
    issue(0, 32'h400, 1, 32'hFFFFFFFF, 4'hF, {1'b1, 32'h0}, 2);
    issue(0, 32'h0, 1, 32'h22222222, 4'h0, {1'b0, 32'h0}, 2);
    issue(0, 32'h0, 0, 32'h0, 4'h0, {1'b0, 32'h11111111}, 2);
    // back-pressure: response held while a second request waits
    rr_a = 0;
    qa.push_back({1'b0, 32'hDEADBEAA});
    set_req(32'h10, 0, 32'h0, 4'h0);
    vld_a = 1;
    wait_accept(0);
    qa.push_back({1'b0, 32'h11111111});
    set_req(32'h0, 0, 32'h0, 4'h0);
    vld_a = 1;
    repeat (20) if (!ok) begin @(negedge clk); ok = rsp_valid_a; end
    chk("hold_valid_seen", {31'd0, ok}, 32'd1);
    repeat (5) begin
      @(negedge clk);
      chk("hold_req_ready", {31'd0, rdy_a}, 32'd0);
      chk("hold_rsp_valid", {31'd0, rsp_valid_a}, 32'd1);
      chk("hold_rdata", rdata_a, 32'hDEADBEAA);
    end
    @(posedge clk); #1 rr_a = 1;
    @(posedge clk);
    @(negedge clk);
    chk("ready_after_hold", {31'd0, rdy_a}, 32'd1);
    @(posedge clk); #1 vld_a = 0;
    repeat (6) @(posedge clk);
    #1;
    // reset while the write is still in its wait states
    set_req(32'h20, 1, 32'h12345678, 4'hF);
    vld_a = 1;
    wait_accept(0);
    @(posedge clk); #1 reset = 1;
    @(negedge clk);
    chk("wrst_req_ready", {31'd0, rdy_a}, 32'd1);
    chk("wrst_rsp_valid", {31'd0, rsp_valid_a}, 32'd0);
    chk("wrst_rdata", rdata_a, 32'd0);
    chk("wrst_err", {31'd0, err_a}, 32'd0);
    @(posedge clk); #1 reset = 0;
    repeat (5) @(posedge clk);
    #1;
    issue(0, 32'h20, 0, 32'h0, 4'h0, {1'b0, 32'h0BADF00D}, 2);
    issue(1, 32'h8, 1, 32'hCAFEF00D, 4'hF, {1'b0, 32'h0}, 0);
    issue(1, 32'h8, 0, 32'h0, 4'h0, {1'b0, 32'hCAFEF00D}, 0);
    issue(1, 32'h8, 1, 32'h00000005, 4'h1, {1'b0, 32'h0}, 0);
    issue(1, 32'h8, 0, 32'h0, 4'h0, {1'b0, 32'hCAFEF005}, 0);
    issue(1, 32'h9, 0, 32'h0, 4'h0, {1'b1, 32'h0}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("qa_empty", qa.size(), 32'd0);
    chk("qb_empty", qb.size(), 32'd0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
